// File: rtl/packet_ring_buffer.sv
// rtl/packet_ring_buffer.sv - frame FIFO with commit-on-last, abort and overflow drop
module packet_ring_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_first,
    input  logic                  wr_last,
    input  logic                  wr_drop,
    input  logic [DATA_WIDTH-1:0] wrdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rddata,
    output logic                  rd_valid,
    output logic                  rd_first,
    output logic                  rd_last,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic                  frame_dropped,
    output logic [ADDR_WIDTH:0]   wr_pointer,
    output logic [ADDR_WIDTH:0]   rd_pointer
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;
    localparam logic [PW-1:0] ONE   = PW'(1);

    // Entry layout: {first, last, data}
    logic [EW-1:0] mem [2**ADDR_WIDTH];

    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic          frame_open;

    logic [PW-1:0]         wr_ptr_nxt, commit_nxt;
    logic                  open_nxt, drop_nxt, commit_ev;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  full_now, full_commit;
    logic                  rd_fire, read_last_ev;
    logic [EW-1:0]         rd_word;

    assign full_now    = ((wr_ptr - rd_ptr) == DEPTH);
    // Occupancy as it would be once an open frame is rewound for a new wr_first.
    assign full_commit = ((commit_ptr - rd_ptr) == DEPTH);

    assign empty      = (commit_ptr == rd_ptr);
    assign full       = full_now;
    assign wr_pointer = wr_ptr;
    assign rd_pointer = rd_ptr;

    assign rd_fire      = rd_en && !empty;
    assign rd_word      = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign read_last_ev = rd_fire && rd_word[DATA_WIDTH];

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        commit_nxt = commit_ptr;
        open_nxt   = frame_open;
        drop_nxt   = 1'b0;
        commit_ev  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = wr_ptr[ADDR_WIDTH-1:0];
        if (wr_drop) begin
            wr_ptr_nxt = commit_ptr;
            open_nxt   = 1'b0;
            drop_nxt   = frame_open;
        end else if (wr_en && wr_first) begin
            if (full_commit) begin
                wr_ptr_nxt = commit_ptr;
                open_nxt   = 1'b0;
                drop_nxt   = 1'b1;
            end else begin
                // A new first word restarts at the commit point, discarding any open frame.
                mem_we     = 1'b1;
                mem_addr   = commit_ptr[ADDR_WIDTH-1:0];
                wr_ptr_nxt = commit_ptr + ONE;
                drop_nxt   = frame_open;
                if (wr_last) begin
                    commit_nxt = commit_ptr + ONE;
                    open_nxt   = 1'b0;
                    commit_ev  = 1'b1;
                end else begin
                    open_nxt   = 1'b1;
                end
            end
        end else if (wr_en && frame_open) begin
            if (full_now) begin
                wr_ptr_nxt = commit_ptr;
                open_nxt   = 1'b0;
                drop_nxt   = 1'b1;
            end else begin
                mem_we     = 1'b1;
                wr_ptr_nxt = wr_ptr + ONE;
                if (wr_last) begin
                    commit_nxt = wr_ptr + ONE;
                    open_nxt   = 1'b0;
                    commit_ev  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= {wr_first, wr_last, wrdata};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            frame_open    <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            commit_ptr    <= commit_nxt;
            frame_open    <= open_nxt;
            frame_dropped <= drop_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            rddata   <= '0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_ptr   <= rd_ptr + ONE;
                rd_first <= rd_word[DATA_WIDTH+1];
                rd_last  <= rd_word[DATA_WIDTH];
                rddata   <= rd_word[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (commit_ev && !read_last_ev) begin
            pkt_count <= pkt_count + ONE;
        end else if (!commit_ev && read_last_ev) begin
            pkt_count <= pkt_count - ONE;
        end
    end

endmodule

// File: doc/packet_ring_buffer.md
Name: packet_ring_buffer

Overview:
- Single-clock, parametrised frame FIFO between the UDP receive path (byte writer with first/last markers) and the packet consumer.
- Stores each data word with its first/last markers, and makes a frame visible to the reader only after its last word is written.
- Adds a full flag, abort of a partly written frame, overflow frame drop and a complete-packet count.

Parameters:
DATA_WIDTH, 8, width of wrdata/rddata
ADDR_WIDTH, 6, log2 of depth; DEPTH = 2**ADDR_WIDTH entries (default 64)

Ports:
clk  input  1  single clock for all logic
reset  input  1  asynchronous, active-high; clears all state
wr_en  input  1  write strobe
wr_first  input  1  with wr_en: word is the first of a frame
wr_last  input  1  with wr_en: word is the last of a frame
wr_drop  input  1  abort the open frame (e.g. CRC fail)
wrdata  input  DATA_WIDTH  write data
rd_en  input  1  read request
rddata  output  DATA_WIDTH  registered read data
rd_valid  output  1  rddata/rd_first/rd_last are valid this cycle
rd_first  output  1  stored first marker of the word read
rd_last  output  1  stored last marker of the word read
empty  output  1  no committed words are available to read
full  output  1  every entry is occupied (committed or pending)
pkt_count  output  ADDR_WIDTH+1  number of complete frames not yet fully read
frame_dropped  output  1  one-cycle pulse when a frame is discarded
wr_pointer  output  ADDR_WIDTH+1  working write pointer (debug)
rd_pointer  output  ADDR_WIDTH+1  read pointer (debug)

Behaviour:
- Storage: DEPTH entries, each {first, last, data}.
- Pointers: wr_ptr, commit_ptr and rd_ptr, each ADDR_WIDTH+1 bits. They wrap modulo 2*DEPTH; the MSB distinguishes wrap. Memory is indexed by the low ADDR_WIDTH bits.
- full = ((wr_ptr - rd_ptr) == DEPTH).
- empty = (commit_ptr == rd_ptr). Uncommitted words are never readable.
- Write-side flag frame_open: cleared by reset, wr_drop, overflow and an accepted wr_last.
- Write rules, checked in this priority order each cycle:
  1. wr_drop=1: wr_ptr <= commit_ptr; frame_open <= 0; frame_dropped pulses if frame_open was 1. wr_en is ignored that cycle.
  2. wr_en & wr_first:
     - A frame already open is silently discarded: its words are lost and frame_dropped pulses.
     - The word is written at commit_ptr; wr_ptr <= commit_ptr+1; frame_open <= 1.
  3. wr_en & !wr_first & frame_open: the word is written at wr_ptr; wr_ptr increments.
  4. wr_en & !wr_first & !frame_open: the word is ignored; no state changes.
- Overflow: write attempted while full and frame_open=1 → word not written; wr_ptr <= commit_ptr; frame_open <= 0; frame_dropped pulses. Following words are ignored until the next wr_first.
- Overflow with wr_first: if full is still 1 after the rewind to commit_ptr, the frame is dropped the same way.
- Commit: an accepted write with wr_last set → commit_ptr <= new wr_ptr; frame_open <= 0; pkt_count increments. A single-word frame has wr_first=wr_last=1.
- Read: rd_en & !empty → on the next edge, rddata/rd_first/rd_last are loaded from mem[rd_ptr], rd_valid=1 and rd_ptr increments. Latency is 1 cycle.
- rd_en while empty → rd_valid=0, no state change.
- rddata, rd_first and rd_last hold their last values when no read occurs.
- Reading a word with its last marker set decrements pkt_count.
- Same cycle commit and read-last → pkt_count unchanged.
- Same cycle read and write → both proceed. full and empty are evaluated on pre-edge register values, so space freed by a read is usable on the next cycle.
- Reset values: rddata=0, rd_valid=0, rd_first=0, rd_last=0, empty=1, full=0, pkt_count=0, frame_dropped=0, all pointers=0.
- Reset in mid-frame or mid-read loses all contents.

Test Plan:
- Write frame 17,8,100,42 (first on 17, last on 42), then hold rd_en → empty 1 until the edge after 42 is written. Reads return 17(first),8,100,42(last) on consecutive cycles, then empty=1, pkt_count back to 0, both pointers=4.
- Write 17,8, then wr_drop → frame_dropped pulses, empty stays 1, wr_pointer returns to 0. The next frame 5,6(last) reads back as 5,6.
- DEPTH=64: write a 65-word frame with no reads → full=1 after 64 words, frame_dropped on the 65th, empty=1, pkt_count=0, wr_pointer=0.
- Wrap: write 3 frames of 40 words while reading concurrently → all 120 words in order, first/last markers correct, pointers end at 120 mod 128.
- wr_en with no frame open and no wr_first → ignored, pointers unchanged.
- Assert reset mid-frame with data committed → all outputs at reset values immediately; a fresh frame after release reads back correctly.
